ysyx_22050058_bus_arbiter: RTL and testbench

- Shares the core's single memory bus port between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences each bus transaction through a small FSM and returns data and a one-cycle ready pulse to the granted stage.
- Raises per-stage stall requests toward the pipeline stall/flush controller while a stage waits.
- Honours an IF flush so that a squashed fetch is dropped.

---
 rtl/ysyx_22050058_bus_arbiter.sv | 98 +++++++++
 tb/tb_ysyx_22050058_bus_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050058_bus_arbiter.sv
// ysyx_22050058_bus_arbiter: shares one memory bus between IF fetches and MEM loads/stores,
// with MEM priority, per-stage stall requests, fetch flush and a bus timeout.
module ysyx_22050058_bus_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   input  logic                if_flush_i,
   output logic                if_ready_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                mem_req_i,
   input  logic                mem_we_i,
   input  logic [ADDR_W-1:0]   mem_addr_i,
   input  logic [DATA_W-1:0]   mem_wdata_i,
   input  logic [DATA_W/8-1:0] mem_wmask_i,
   output logic                mem_ready_o,
   output logic [DATA_W-1:0]   mem_rdata_o,
   output logic                bus_valid_o,
   output logic                bus_we_o,
   output logic [ADDR_W-1:0]   bus_addr_o,
   output logic [DATA_W-1:0]   bus_wdata_o,
   output logic [DATA_W/8-1:0] bus_wmask_o,
   input  logic                bus_ready_i,
   input  logic [DATA_W-1:0]   bus_rdata_i,
   output logic                bus_err_o,
   output logic                stall_ifreq_o,
   output logic                stall_memreq_o
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, RESP} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic drop, owner_mem, err;
   logic busy, expire, grant_mem, grant_if;
   assign busy      = (state == IF_BUSY) || (state == MEM_BUSY);
   assign expire    = busy && !bus_ready_i && (cnt == CW'(TIMEOUT - 1));
   assign grant_mem = (state == IDLE) && mem_req_i;
   assign grant_if  = (state == IDLE) && !mem_req_i && if_req_i && !if_flush_i;
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:              state_n = grant_mem ? MEM_BUSY : grant_if ? IF_BUSY : IDLE;
         IF_BUSY, MEM_BUSY: state_n = (bus_ready_i || expire) ? RESP : state;
         default:           state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         drop        <= 1'b0;
         owner_mem   <= 1'b0;
         err         <= 1'b0;
         bus_valid_o <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         bus_wmask_o <= '0;
         if_rdata_o  <= '0;
         mem_rdata_o <= '0;
      end else begin
         state <= state_n;
         if (grant_mem || grant_if) begin
            owner_mem   <= grant_mem;
            bus_valid_o <= 1'b1;
            bus_we_o    <= grant_mem & mem_we_i;
            bus_addr_o  <= grant_mem ? mem_addr_i : if_addr_i;
            bus_wdata_o <= grant_mem ? mem_wdata_i : '0;
            bus_wmask_o <= grant_mem ? mem_wmask_i : '0;
         end
         if (busy) begin
            cnt <= cnt + CW'(1);
            if (state == IF_BUSY && if_flush_i) drop <= 1'b1;
            // the beat is never withdrawn early; only completion or timeout ends it
            if (bus_ready_i || expire) begin
               bus_valid_o <= 1'b0;
               err         <= expire;
               if (owner_mem) mem_rdata_o <= bus_ready_i ? bus_rdata_i : '0;
               else if_rdata_o <= bus_ready_i ? bus_rdata_i : '0;
            end
         end
         if (state == RESP) begin
            cnt  <= '0;
            drop <= 1'b0;
            err  <= 1'b0;
         end
      end
   end
   assign if_ready_o     = (state == RESP) && !owner_mem && !drop && !if_flush_i;
   assign mem_ready_o    = (state == RESP) && owner_mem;
   assign bus_err_o      = (state == RESP) && err;
   assign stall_memreq_o = mem_req_i & ~mem_ready_o;
   assign stall_ifreq_o  = if_req_i & ~if_ready_o & ~if_flush_i;
endmodule

// File: tb/tb_ysyx_22050058_bus_arbiter.sv
// tb_ysyx_22050058_bus_arbiter: directed transaction table plus hand sequences for
// conflict, flush, timeout and asynchronous reset.
module tb_ysyx_22050058_bus_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic if_req = 1'b0, if_flush = 1'b0, if_ready;
   logic mem_req = 1'b0, mem_we = 1'b0, mem_ready;
   logic bus_valid, bus_we, bus_ready = 1'b0, bus_err, stall_if, stall_mem;
   logic [63:0] if_addr = '0, if_rdata, mem_addr = '0, mem_wdata = '0, mem_rdata;
   logic [63:0] bus_addr, bus_wdata, bus_rdata = '0;
   logic [7:0] mem_wmask = '0, bus_wmask;
   int checks = 0, errors = 0;
   logic [63:0] last_if = '0, last_mem = '0;

   typedef struct {
      bit          is_mem;
      bit          we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      int          waits;
      logic [63:0] rdata;
   } txn_t;

   ysyx_22050058_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
      .if_ready_o(if_ready), .if_rdata_o(if_rdata),
      .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
      .mem_wdata_i(mem_wdata), .mem_wmask_i(mem_wmask),
      .mem_ready_o(mem_ready), .mem_rdata_o(mem_rdata),
      .bus_valid_o(bus_valid), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
      .bus_wdata_o(bus_wdata), .bus_wmask_o(bus_wmask),
      .bus_ready_i(bus_ready), .bus_rdata_i(bus_rdata), .bus_err_o(bus_err),
      .stall_ifreq_o(stall_if), .stall_memreq_o(stall_mem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_txn(input txn_t t);
      @(negedge clk);
      if (t.is_mem) begin
         mem_req = 1'b1; mem_we = t.we; mem_addr = t.addr; mem_wdata = t.wdata; mem_wmask = t.wmask;
      end else begin
         if_req = 1'b1; if_addr = t.addr;
      end
      #1 chk("stall_pre", 64'(t.is_mem ? stall_mem : stall_if), 64'd1);
      for (int c = 0; c <= t.waits; c++) begin
         @(negedge clk);
         chk("bus_valid", 64'(bus_valid), 64'd1);
         chk("bus_addr", bus_addr, t.addr);
         chk("bus_we", 64'(bus_we), 64'(t.is_mem & t.we));
         chk("bus_wmask", 64'(bus_wmask), t.is_mem ? 64'(t.wmask) : 64'd0);
         if (t.is_mem) chk("bus_wdata", bus_wdata, t.wdata);
         chk("ready_busy", 64'(t.is_mem ? mem_ready : if_ready), 64'd0);
         chk("stall_busy", 64'(t.is_mem ? stall_mem : stall_if), 64'd1);
         if (c == t.waits) begin bus_ready = 1'b1; bus_rdata = t.rdata; end
      end
      @(negedge clk);
      bus_ready = 1'b0;
      chk("ready_resp", 64'(t.is_mem ? mem_ready : if_ready), 64'd1);
      chk("rdata", t.is_mem ? mem_rdata : if_rdata, t.rdata);
      chk("hold_other", t.is_mem ? if_rdata : mem_rdata, t.is_mem ? last_if : last_mem);
      chk("valid_resp", 64'(bus_valid), 64'd0);
      chk("err_resp", 64'(bus_err), 64'd0);
      chk("stall_resp", 64'(t.is_mem ? stall_mem : stall_if), 64'd0);
      if (t.is_mem) last_mem = t.rdata; else last_if = t.rdata;
      mem_req = 1'b0; if_req = 1'b0;
      @(negedge clk);
      chk("ready_after", 64'(t.is_mem ? mem_ready : if_ready), 64'd0);
   endtask

   txn_t tbl[5];

   initial begin
      tbl[0] = '{0, 0, 64'h8000_0000, 64'h0, 8'h00, 1, 64'h13};
      tbl[1] = '{1, 1, 64'h8000_0100, 64'hDEADBEEF, 8'h0F, 2, 64'h5555};
      tbl[2] = '{1, 0, 64'h8000_0108, 64'h0, 8'h00, 0, 64'h1122_3344_5566_7788};
      tbl[3] = '{0, 0, 64'h8000_0004, 64'h0, 8'h00, 3, 64'h0010_0093};
      tbl[4] = '{1, 0, 64'h8000_0110, 64'h0, 8'h00, 0, 64'hCAFE};

      #12;
      chk("rst_valid", 64'(bus_valid), 64'd0);
      chk("rst_addr", bus_addr, 64'd0);
      chk("rst_if_ready", 64'(if_ready), 64'd0);
      chk("rst_mem_ready", 64'(mem_ready), 64'd0);
      chk("rst_err", 64'(bus_err), 64'd0);
      chk("rst_rdata", if_rdata | mem_rdata, 64'd0);
      @(negedge clk) rst = 1'b0;

      foreach (tbl[i]) run_txn(tbl[i]);

      // conflict: MEM first, IF after MEM's RESP
      @(negedge clk);
      if_req = 1'b1; if_addr = 64'h8000_0300;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h8000_0400;
      @(negedge clk);
      chk("cf_mem_addr", bus_addr, 64'h8000_0400);
      chk("cf_valid1", 64'(bus_valid), 64'd1);
      chk("cf_stall_if", 64'(stall_if), 64'd1);
      bus_ready = 1'b1; bus_rdata = 64'hAB;
      @(negedge clk);
      bus_ready = 1'b0;
      chk("cf_mem_ready", 64'(mem_ready), 64'd1);
      chk("cf_mem_rdata", mem_rdata, 64'hAB);
      chk("cf_if_ready0", 64'(if_ready), 64'd0);
      mem_req = 1'b0;
      @(negedge clk);
      chk("cf_idle_valid", 64'(bus_valid), 64'd0);
      chk("cf_stall_if2", 64'(stall_if), 64'd1);
      @(negedge clk);
      chk("cf_if_addr", bus_addr, 64'h8000_0300);
      chk("cf_if_we", 64'(bus_we), 64'd0);
      bus_ready = 1'b1; bus_rdata = 64'hCD;
      @(negedge clk);
      bus_ready = 1'b0;
      chk("cf_if_ready", 64'(if_ready), 64'd1);
      chk("cf_if_rdata", if_rdata, 64'hCD);
      chk("cf_mem_hold", mem_rdata, 64'hAB);
      if_req = 1'b0; last_if = 64'hCD; last_mem = 64'hAB;

      // flush mid-fetch: beat completes, no ready pulse
      @(negedge clk);
      if_req = 1'b1; if_addr = 64'h8000_0500;
      @(negedge clk);
      chk("fl_valid", 64'(bus_valid), 64'd1);
      if_flush = 1'b1; if_req = 1'b0;
      @(negedge clk);
      if_flush = 1'b0;
      chk("fl_held", 64'(bus_valid), 64'd1);
      chk("fl_addr", bus_addr, 64'h8000_0500);
      bus_ready = 1'b1; bus_rdata = 64'h77;
      @(negedge clk);
      bus_ready = 1'b0;
      chk("fl_no_ready", 64'(if_ready), 64'd0);
      chk("fl_valid_drop", 64'(bus_valid), 64'd0);
      @(negedge clk);
      chk("fl_no_ready2", 64'(if_ready), 64'd0);
      last_if = 64'h77;
      run_txn('{0, 0, 64'h8000_0200, 64'h0, 8'h00, 0, 64'h99});

      // timeout: 4 BUSY cycles, then err + ready with zero data
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h8000_0600;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("to_valid", 64'(bus_valid), 64'd1);
         chk("to_err0", 64'(bus_err), 64'd0);
      end
      @(negedge clk);
      chk("to_valid_drop", 64'(bus_valid), 64'd0);
      chk("to_err", 64'(bus_err), 64'd1);
      chk("to_ready", 64'(mem_ready), 64'd1);
      chk("to_rdata", mem_rdata, 64'd0);
      mem_req = 1'b0; last_mem = 64'd0;
      @(negedge clk);
      chk("to_err_once", 64'(bus_err), 64'd0);
      chk("to_ready_once", 64'(mem_ready), 64'd0);

      // asynchronous reset during MEM_BUSY
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h8000_0700; mem_wdata = 64'h1; mem_wmask = 8'hFF;
      @(negedge clk);
      chk("ar_valid", 64'(bus_valid), 64'd1);
      #2 rst = 1'b1;
      #1 chk("ar_valid_async", 64'(bus_valid), 64'd0);
      chk("ar_addr_async", bus_addr, 64'd0);
      mem_req = 1'b0;
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("ar_no_ready", 64'(mem_ready), 64'd0);
         chk("ar_no_valid", 64'(bus_valid), 64'd0);
      end
      last_if = 64'd0; last_mem = 64'd0;
      run_txn('{1, 0, 64'h8000_0800, 64'h0, 8'h00, 1, 64'hBEEF});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
